// File: rtl/regfile_write_sched.sv
// Purpose : shares WRITES register-file write ports among REQS requesters using
//           round-robin valid/ready arbitration, and sweeps a full-array clear after
//           reset or on request.
// Latency : 1 cycle from handshake (valid & ready) to write_en/write_index/write_data.
// Backpressure: req_ready is combinational. It is 0 while busy, in a clear_start
//           cycle, and for requesters beyond the port count or with a same-cycle index clash.
// Ports   : clk/rst_n (sync, active-low) | clear_start pulse | req_valid/req_ready/
//           req_index/req_data per requester (packed slots) | write_en/write_index/
//           write_data per port (packed, registered) | busy (registered, 1 in CLEAR)
module regfile_write_sched #(
    parameter int                 REQS         = 4,
    parameter int                 WRITES       = 2,
    parameter int                 WIDTH        = 32,
    parameter int                 N            = 5,
    parameter int                 SIZE         = 32,
    parameter int                 CLEAR_ON_RST = 1,
    parameter logic [WIDTH-1:0]   CLEAR_VAL    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_start,
    input  logic [REQS-1:0]          req_valid,
    output logic [REQS-1:0]          req_ready,
    input  logic [REQS*N-1:0]        req_index,
    input  logic [REQS*WIDTH-1:0]    req_data,
    output logic [WRITES-1:0]        write_en,
    output logic [WRITES*N-1:0]      write_index,
    output logic [WRITES*WIDTH-1:0]  write_data,
    output logic                     busy
);

    localparam int RW = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int CW = $clog2(SIZE + WRITES + 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [RW-1:0]              r_rr_ptr;
    logic [CW-1:0]              r_clr_cnt;
    logic [WRITES-1:0]          r_wr_en;
    logic [WRITES*N-1:0]        r_wr_index;
    logic [WRITES*WIDTH-1:0]    r_wr_data;
    logic                       r_busy;

    // Arbitration results
    logic [REQS-1:0]            w_ready;
    logic [WRITES-1:0]          w_port_vld;
    int                         w_port_sel [WRITES];
    logic [N-1:0]               w_gidx     [WRITES];
    int                         w_cnt;
    int                         w_last;
    int                         w_r;
    logic                       w_hit;
    logic                       w_grant_any;

    // Round-robin scan starting at r_rr_ptr. A requester whose index clashes with an
    // index already granted this cycle is skipped without using up a port, so later
    // requesters in scan order can still take the remaining ports.
    always_comb begin
        w_ready     = '0;
        w_port_vld  = '0;
        w_cnt       = 0;
        w_last      = 0;
        w_r         = 0;
        w_hit       = 1'b0;
        w_grant_any = 1'b0;
        for (int k = 0; k < WRITES; k++) begin
            w_port_sel[k] = 0;
            w_gidx[k]     = '0;
        end
        if (r_state == S_RUN && !clear_start) begin
            for (int j = 0; j < REQS; j++) begin
                w_r   = (int'(r_rr_ptr) + j) % REQS;
                w_hit = 1'b0;
                for (int k = 0; k < WRITES; k++) begin
                    if (k < w_cnt && w_gidx[k] == req_index[w_r*N +: N]) begin
                        w_hit = 1'b1;
                    end
                end
                if (req_valid[w_r] && w_cnt < WRITES && !w_hit) begin
                    w_ready[w_r] = 1'b1;
                    for (int k = 0; k < WRITES; k++) begin
                        if (k == w_cnt) begin
                            w_gidx[k]     = req_index[w_r*N +: N];
                            w_port_sel[k] = w_r;
                            w_port_vld[k] = 1'b1;
                        end
                    end
                    w_cnt       = w_cnt + 1;
                    w_last      = w_r;
                    w_grant_any = 1'b1;
                end
            end
        end
    end

    assign req_ready = w_ready;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (int'(r_clr_cnt) + WRITES >= SIZE) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (clear_start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
            r_rr_ptr   <= '0;
            r_clr_cnt  <= '0;
            r_wr_en    <= '0;
            r_wr_index <= '0;
            r_wr_data  <= '0;
            r_busy     <= (CLEAR_ON_RST != 0);
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_CLEAR);
            if (r_state == S_CLEAR) begin
                // Ports past the end of the array in the final sweep cycle stay disabled.
                for (int k = 0; k < WRITES; k++) begin
                    r_wr_en[k]                <= (int'(r_clr_cnt) + k < SIZE);
                    r_wr_index[k*N +: N]      <= N'(int'(r_clr_cnt) + k);
                    r_wr_data[k*WIDTH +: WIDTH] <= CLEAR_VAL;
                end
                r_clr_cnt <= r_clr_cnt + CW'(WRITES);
            end else begin
                // Idle ports hold index/data so the register-file inputs don't toggle.
                for (int k = 0; k < WRITES; k++) begin
                    r_wr_en[k] <= w_port_vld[k];
                    if (w_port_vld[k]) begin
                        r_wr_index[k*N +: N]        <= req_index[w_port_sel[k]*N +: N];
                        r_wr_data[k*WIDTH +: WIDTH] <= req_data[w_port_sel[k]*WIDTH +: WIDTH];
                    end
                end
                if (w_grant_any) begin
                    r_rr_ptr <= RW'((w_last + 1) % REQS);
                end
                // Held at 0 so a clear requested from RUN starts at entry 0.
                r_clr_cnt <= '0;
            end
        end
    end

    assign write_en    = r_wr_en;
    assign write_index = r_wr_index;
    assign write_data  = r_wr_data;
    assign busy        = r_busy;

endmodule
